// File: rtl/sdram_port_arb.sv
// sdram_port_arb
// Arbitrates one SDRAM controller port between three clients: a ROM-download
// writer (one-entry buffered, stalled through dl_wait) and two read clients,
// sprite fetch and tile (background) fetch. Only one access is ever
// outstanding. A download write always beats the reads. Two reads that tie
// alternate, starting with the sprite client after reset.
//
// Ports
//   clk_sys, reset_n               clock, asynchronous active-low reset
//   dl_wr/dl_addr/dl_data          download write strobe, address and data
//   dl_wait                        download buffer occupied (loader stall)
//   spr_req/spr_addr               sprite read request (level) and address
//   spr_data/spr_valid             sprite read data and one-cycle valid
//   bg_req/bg_addr                 tile read request (level) and address
//   bg_data/bg_valid               tile read data and one-cycle valid
//   mem_addr/mem_din               controller address and write data
//   mem_rd/mem_we                  controller read and write strobes
//   mem_dout/mem_ready             controller read data and completion pulse
//   busy                           FSM not in IDLE
//   err                            sticky timeout flag
module sdram_port_arb #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 63
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic [7:0]        spr_data,
  output logic              spr_valid,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic [7:0]        bg_data,
  output logic              bg_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);

  // The WAIT counter only has to reach TIMEOUT-1: the abort happens at the
  // end of the TIMEOUT-th WAIT cycle.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_r,     state_s;
  logic [CNT_W-1:0]  cnt_r,       cnt_s;
  logic              dl_full_r,   dl_full_s;
  logic [ADDR_W-1:0] dl_addr_r,   dl_addr_s;
  logic [7:0]        dl_data_r,   dl_data_s;
  logic              rr_bg_r,     rr_bg_s;     // 1: tile client wins the next tie
  logic              gnt_wr_r,    gnt_wr_s;    // access in flight is the download write
  logic              gnt_bg_r,    gnt_bg_s;    // read in flight belongs to the tile client
  logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
  logic [7:0]        mem_din_r,   mem_din_s;
  logic              mem_rd_r,    mem_rd_s;
  logic              mem_we_r,    mem_we_s;
  logic [7:0]        spr_data_r,  spr_data_s;
  logic              spr_valid_r, spr_valid_s;
  logic [7:0]        bg_data_r,   bg_data_s;
  logic              bg_valid_r,  bg_valid_s;
  logic              busy_r,      busy_s;
  logic              err_r,       err_s;
  logic              pick_bg_s;
  logic [7:0]        rd_byte_s;

  // FSM next state plus next values of every registered output.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    dl_full_s   = dl_full_r;
    dl_addr_s   = dl_addr_r;
    dl_data_s   = dl_data_r;
    rr_bg_s     = rr_bg_r;
    gnt_wr_s    = gnt_wr_r;
    gnt_bg_s    = gnt_bg_r;
    mem_addr_s  = mem_addr_r;
    mem_din_s   = mem_din_r;
    mem_rd_s    = 1'b0;
    mem_we_s    = 1'b0;
    spr_data_s  = spr_data_r;
    spr_valid_s = 1'b0;
    bg_data_s   = bg_data_r;
    bg_valid_s  = 1'b0;
    err_s       = err_r;
    pick_bg_s   = bg_req && (!spr_req || rr_bg_r);
    rd_byte_s   = mem_ready ? mem_dout : 8'hFF;

    // A write arriving while the buffer is full is simply lost.
    if (dl_wr && !dl_full_r) begin
      dl_full_s = 1'b1;
      dl_addr_s = dl_addr;
      dl_data_s = dl_data;
    end else begin
      dl_full_s = dl_full_r;
    end

    case (state_r)
      IDLE: begin
        // A write sampled on this very edge already counts as pending.
        if (dl_full_r || dl_wr) begin
          gnt_wr_s   = 1'b1;
          gnt_bg_s   = 1'b0;
          mem_addr_s = dl_full_r ? dl_addr_r : dl_addr;
          mem_din_s  = dl_full_r ? dl_data_r : dl_data;
          mem_we_s   = 1'b1;
          state_s    = ISSUE;
        end else if (spr_req || bg_req) begin
          // The tie pointer moves only when both clients compete.
          rr_bg_s    = (spr_req && bg_req) ? !rr_bg_r : rr_bg_r;
          gnt_wr_s   = 1'b0;
          gnt_bg_s   = pick_bg_s;
          mem_addr_s = pick_bg_s ? bg_addr : spr_addr;
          mem_rd_s   = 1'b1;
          state_s    = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // The strobe is high during this cycle; waiting starts next cycle.
        cnt_s   = {CNT_W{1'b0}};
        state_s = WAIT;
      end
      WAIT: begin
        if (mem_ready || (cnt_r == CNT_LAST)) begin
          err_s = mem_ready ? err_r : 1'b1;
          if (gnt_wr_r) begin
            dl_full_s = 1'b0;
          end else if (gnt_bg_r) begin
            bg_data_s  = rd_byte_s;
            bg_valid_s = 1'b1;
          end else begin
            spr_data_s  = rd_byte_s;
            spr_valid_s = 1'b1;
          end
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers, cleared asynchronously at any point.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      dl_full_r   <= 1'b0;
      dl_addr_r   <= {ADDR_W{1'b0}};
      dl_data_r   <= 8'h00;
      rr_bg_r     <= 1'b0;
      gnt_wr_r    <= 1'b0;
      gnt_bg_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_din_r   <= 8'h00;
      mem_rd_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      spr_data_r  <= 8'h00;
      spr_valid_r <= 1'b0;
      bg_data_r   <= 8'h00;
      bg_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      dl_full_r   <= dl_full_s;
      dl_addr_r   <= dl_addr_s;
      dl_data_r   <= dl_data_s;
      rr_bg_r     <= rr_bg_s;
      gnt_wr_r    <= gnt_wr_s;
      gnt_bg_r    <= gnt_bg_s;
      mem_addr_r  <= mem_addr_s;
      mem_din_r   <= mem_din_s;
      mem_rd_r    <= mem_rd_s;
      mem_we_r    <= mem_we_s;
      spr_data_r  <= spr_data_s;
      spr_valid_r <= spr_valid_s;
      bg_data_r   <= bg_data_s;
      bg_valid_r  <= bg_valid_s;
      busy_r      <= busy_s;
      err_r       <= err_s;
    end
  end

  assign dl_wait   = dl_full_r;
  assign spr_data  = spr_data_r;
  assign spr_valid = spr_valid_r;
  assign bg_data   = bg_data_r;
  assign bg_valid  = bg_valid_r;
  assign mem_addr  = mem_addr_r;
  assign mem_din   = mem_din_r;
  assign mem_rd    = mem_rd_r;
  assign mem_we    = mem_we_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Testbench for sdram_port_arb: table of single-read vectors plus hand-written
// sequences for download, priority, tie alternation, timeout and reset cases.
// Expected read results and writes go into queues as stimulus is driven; a
// negedge monitor pops and compares them as the DUT produces them.
module tb_sdram_port_arb;

  localparam int ADDR_W  = 25;
  localparam int TIMEOUT = 63;

  logic              clk_sys;
  logic              reset_n;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_wait;
  logic              spr_req;
  logic [ADDR_W-1:0] spr_addr;
  logic [7:0]        spr_data;
  logic              spr_valid;
  logic              bg_req;
  logic [ADDR_W-1:0] bg_addr;
  logic [7:0]        bg_data;
  logic              bg_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_rd;
  logic              mem_we;
  logic [7:0]        mem_dout;
  logic              mem_ready;
  logic              busy;
  logic              err;

  sdram_port_arb #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_data(spr_data), .spr_valid(spr_valid),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_data(bg_data), .bg_valid(bg_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit                bg;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dout;
    int                delay;     // cycles from ISSUE to mem_ready; 0 = never
    logic [7:0]        exp_data;
    bit                exp_err;
  } vec_t;

  typedef struct { bit bg; logic [7:0] data; } rd_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] data; } wr_exp_t;

  vec_t       vecs [6];
  rd_exp_t    rd_q [$];
  wr_exp_t    wr_q [$];
  rd_exp_t    mon_r;
  wr_exp_t    mon_w;
  int         n_vec = 0;
  int         n_bad = 0;
  int         we_cnt = 0;
  int         base;
  logic [7:0] m_spr = 8'h00;
  logic [7:0] m_bg  = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({dl_wait, spr_data, spr_valid, bg_data, bg_valid, mem_addr,
                mem_din, mem_rd, mem_we, busy, err});
  endfunction

  // Scoreboard side: compare every strobe and valid pulse against the queues.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (mem_rd || mem_we) check("rd_we exclusive", 64'(mem_rd & mem_we), 64'd0);
      if (mem_we) begin
        we_cnt++;
        if (wr_q.size() == 0) check("unexpected mem_we", 64'd1, 64'd0);
        else begin
          mon_w = wr_q.pop_front();
          check("mem_we addr", 64'(mem_addr), 64'(mon_w.addr));
          check("mem_we din", 64'(mem_din), 64'(mon_w.data));
        end
      end
      if (spr_valid) begin
        if (rd_q.size() == 0) check("unexpected spr_valid", 64'd1, 64'd0);
        else begin
          mon_r = rd_q.pop_front();
          check("spr_valid owner", 64'(mon_r.bg), 64'd0);
          check("spr_data", 64'(spr_data), 64'(mon_r.data));
        end
      end
      if (bg_valid) begin
        if (rd_q.size() == 0) check("unexpected bg_valid", 64'd1, 64'd0);
        else begin
          mon_r = rd_q.pop_front();
          check("bg_valid owner", 64'(mon_r.bg), 64'd1);
          check("bg_data", 64'(bg_data), 64'(mon_r.data));
        end
      end
    end
  end

  // Serve one read whose request was driven at the current negedge.
  task automatic rd_phase(input bit bg, input logic [ADDR_W-1:0] addr, input logic [7:0] dout,
                          input int delay, input logic [7:0] exp_d, input string tag);
    int n;
    rd_q.push_back('{bg, exp_d});
    @(negedge clk_sys);
    check({tag, " issue"}, 64'(mem_rd), 64'd1);
    check({tag, " addr"}, 64'(mem_addr), 64'(addr));
    n = 0;
    if (delay > 0) begin
      repeat (delay) @(negedge clk_sys);
      n = delay;
      check({tag, " addr hold"}, 64'(mem_addr), 64'(addr));
      mem_ready = 1'b1;
      mem_dout  = dout;
      @(negedge clk_sys);
      n++;
      mem_ready = 1'b0;
      mem_dout  = 8'h00;
    end
    while (!(bg ? bg_valid : spr_valid) && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(delay > 0 ? delay + 1 : TIMEOUT + 1));
    check({tag, " busy"}, 64'(busy), 64'd0);
    if (bg) begin
      bg_req = 1'b0;
      m_bg   = exp_d;
    end else begin
      spr_req = 1'b0;
      m_spr   = exp_d;
    end
    check({tag, " spr_data reg"}, 64'(spr_data), 64'(m_spr));
    check({tag, " bg_data reg"}, 64'(bg_data), 64'(m_bg));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 25'h0000100, 8'h3C, 1,  8'h3C, 1'b0};
    vecs[1] = '{1'b1, 25'h1FFFFFF, 8'hC3, 2,  8'hC3, 1'b0};
    vecs[2] = '{1'b0, 25'h1234567, 8'h00, 5,  8'h00, 1'b0};
    vecs[3] = '{1'b1, 25'h0000000, 8'hFE, 63, 8'hFE, 1'b0};
    vecs[4] = '{1'b0, 25'h0AAAAAA, 8'h5A, 0,  8'hFF, 1'b1};
    vecs[5] = '{1'b1, 25'h1555555, 8'h77, 3,  8'h77, 1'b1};

    reset_n = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = 8'h00;
    spr_req = 1'b0; spr_addr = '0; bg_req = 1'b0; bg_addr = '0;
    mem_dout = 8'h00; mem_ready = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset outputs", all_outs(), 64'd0);

    // Download write granted on the first edge after reset release.
    reset_n = 1'b1;
    dl_wr = 1'b1; dl_addr = 25'h0000010; dl_data = 8'hA5;
    wr_q.push_back('{25'h0000010, 8'hA5});
    check("dl_wait before capture", 64'(dl_wait), 64'd0);
    @(negedge clk_sys);
    dl_wr = 1'b0;
    check("dl_wait after capture", 64'(dl_wait), 64'd1);
    check("dl mem_we", 64'(mem_we), 64'd1);
    repeat (3) @(negedge clk_sys);
    check("dl_wait in ready cycle", 64'(dl_wait), 64'd1);
    mem_ready = 1'b1;
    @(negedge clk_sys);
    mem_ready = 1'b0;
    check("dl_wait after ready", 64'(dl_wait), 64'd0);
    check("dl busy after ready", 64'(busy), 64'd0);
    check("dl we count", 64'(we_cnt), 64'd1);

    // Tie: sprite first after reset, then tile wins the next tie, then sprite.
    @(negedge clk_sys);
    spr_req = 1'b1; spr_addr = 25'h0000111; bg_req = 1'b1; bg_addr = 25'h0000222;
    rd_phase(1'b0, 25'h0000111, 8'h11, 2, 8'h11, "tie1 spr");
    rd_phase(1'b1, 25'h0000222, 8'h22, 2, 8'h22, "tie1 bg");
    @(negedge clk_sys);
    spr_req = 1'b1; bg_req = 1'b1;
    rd_phase(1'b1, 25'h0000222, 8'h44, 1, 8'h44, "tie2 bg");
    rd_phase(1'b0, 25'h0000111, 8'h33, 1, 8'h33, "tie2 spr");

    // Download beats a tile read sampled on the same edge.
    @(negedge clk_sys);
    bg_req = 1'b1; bg_addr = 25'h00ABCDE;
    dl_wr = 1'b1; dl_addr = 25'h0001234; dl_data = 8'h3E;
    wr_q.push_back('{25'h0001234, 8'h3E});
    @(negedge clk_sys);
    dl_wr = 1'b0;
    check("prio mem_we", 64'(mem_we), 64'd1);
    check("prio no mem_rd", 64'(mem_rd), 64'd0);
    repeat (2) begin
      @(negedge clk_sys);
      check("prio rd held off", 64'(mem_rd), 64'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk_sys);
    mem_ready = 1'b0;
    rd_phase(1'b1, 25'h00ABCDE, 8'h66, 2, 8'h66, "prio bg");

    // Second download write while the buffer is full is dropped.
    base = we_cnt;
    @(negedge clk_sys);
    dl_wr = 1'b1; dl_addr = 25'h0002000; dl_data = 8'h5C;
    wr_q.push_back('{25'h0002000, 8'h5C});
    @(negedge clk_sys);
    check("dup dl_wait", 64'(dl_wait), 64'd1);
    dl_addr = 25'h0003000; dl_data = 8'hC5;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    @(negedge clk_sys);
    mem_ready = 1'b1;
    @(negedge clk_sys);
    mem_ready = 1'b0;
    check("dup dl_wait released", 64'(dl_wait), 64'd0);
    repeat (6) @(negedge clk_sys);
    check("dup we count", 64'(we_cnt - base), 64'd1);

    // Single-read vectors, including the last-cycle ready and the timeout.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      if (vecs[i].bg) begin
        bg_req = 1'b1; bg_addr = vecs[i].addr;
      end else begin
        spr_req = 1'b1; spr_addr = vecs[i].addr;
      end
      rd_phase(vecs[i].bg, vecs[i].addr, vecs[i].dout, vecs[i].delay,
               vecs[i].exp_data, $sformatf("vec%0d", i));
      check($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].exp_err));
    end

    // One more tie so the pointer favours the tile client before reset.
    @(negedge clk_sys);
    spr_req = 1'b1; spr_addr = 25'h0000111; bg_req = 1'b1; bg_addr = 25'h0000222;
    rd_phase(1'b0, 25'h0000111, 8'h55, 1, 8'h55, "tie3 spr");
    rd_phase(1'b1, 25'h0000222, 8'h56, 1, 8'h56, "tie3 bg");

    // Reset in the middle of WAIT, then a stray mem_ready.
    @(negedge clk_sys);
    spr_req = 1'b1; spr_addr = 25'h00F0F0F;
    @(negedge clk_sys);
    check("rst issue", 64'(mem_rd), 64'd1);
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1 check("async reset outputs", all_outs(), 64'd0);
    spr_req = 1'b0;
    m_spr = 8'h00; m_bg = 8'h00;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    mem_ready = 1'b1; mem_dout = 8'h99;
    @(negedge clk_sys);
    mem_ready = 1'b0; mem_dout = 8'h00;
    repeat (6) @(negedge clk_sys);
    check("late ready outputs", all_outs(), 64'd0);

    // Pointer back to the sprite client after reset.
    spr_req = 1'b1; spr_addr = 25'h0000AAA; bg_req = 1'b1; bg_addr = 25'h0000BBB;
    rd_phase(1'b0, 25'h0000AAA, 8'h12, 1, 8'h12, "rst tie spr");
    rd_phase(1'b1, 25'h0000BBB, 8'h34, 1, 8'h34, "rst tie bg");

    repeat (3) @(negedge clk_sys);
    check("read queue drained", 64'(rd_q.size()), 64'd0);
    check("write queue drained", 64'(wr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
